// File: rtl/alu_ctrl_pkg.sv
// Shared types, ALU op encodings and function-field layout for the ALU arbiter slice.
// Op encodings 0xC-0xF are reserved and produce a zero result before output inversion.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DATA_W = 64;
  localparam int F_W    = 7;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 4;
  localparam int SHAMT_W = 6;

  // Function-field bit positions
  localparam int F_INV_A = 6;
  localparam int F_INV_B = 5;
  localparam int F_OP_HI = 4;
  localparam int F_OP_LO = 1;
  localparam int F_INV_Y = 0;

  localparam logic [OP_W-1:0] OP_AND    = 4'h0;
  localparam logic [OP_W-1:0] OP_OR     = 4'h1;
  localparam logic [OP_W-1:0] OP_XOR    = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD    = 4'h3;
  localparam logic [OP_W-1:0] OP_SLT    = 4'h4;
  localparam logic [OP_W-1:0] OP_SLTU   = 4'h5;
  localparam logic [OP_W-1:0] OP_PASS_A = 4'h6;
  localparam logic [OP_W-1:0] OP_PASS_B = 4'h7;
  localparam logic [OP_W-1:0] OP_MUL    = 4'h8;
  localparam logic [OP_W-1:0] OP_MULH   = 4'h9;
  localparam logic [OP_W-1:0] OP_LSHIFT = 4'hA;
  localparam logic [OP_W-1:0] OP_RSHIFT = 4'hB;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/alu.sv
// 64-bit combinational ALU: optional operand/result inversion around a 16-entry op table.
// ADD takes carry-in from the invert-b bit so that a + ~b gives a two's-complement subtract.
module alu
  import alu_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [F_W-1:0]    f,
  output logic [DATA_W-1:0] y,
  output logic              zero
);

  logic [OP_W-1:0]     op;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   res;
  logic [2*DATA_W-1:0] prod;
  logic [SHAMT_W-1:0]  shamt;

  assign op    = f[F_OP_HI:F_OP_LO];
  assign op_a  = f[F_INV_A] ? ~a : a;
  assign op_b  = f[F_INV_B] ? ~b : b;
  assign shamt = op_b[SHAMT_W-1:0];
  assign prod  = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};

  always_comb begin
    res = '0;
    case (op)
      OP_AND:    res = op_a & op_b;
      OP_OR:     res = op_a | op_b;
      OP_XOR:    res = op_a ^ op_b;
      OP_ADD:    res = op_a + op_b + {{(DATA_W-1){1'b0}}, f[F_INV_B]};
      OP_SLT:    res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:   res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      OP_PASS_A: res = op_a;
      OP_PASS_B: res = op_b;
      OP_MUL:    res = prod[DATA_W-1:0];
      OP_MULH:   res = prod[2*DATA_W-1:DATA_W];
      OP_LSHIFT: res = op_a << shamt;
      OP_RSHIFT: res = op_a >> shamt;
      default:   res = '0;
    endcase
  end

  assign y    = f[F_INV_Y] ? ~res : res;
  assign zero = (y == '0);

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone request always wins; on contention ptr names the winner.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = valid[gi] & (~valid[1-gi] | (ptr == 1'(gi)));
    end
  endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 64-bit ALU between two valid/ready requesters, one transaction at a time,
// with round-robin arbitration and a configurable multi-cycle hold for multiply ops.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [F_W-1:0]    req0_f,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [F_W-1:0]    req1_f,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_y,
  output logic              resp0_zero,
  output logic [TAG_W-1:0]  resp0_tag,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_y,
  output logic              resp1_zero,
  output logic [TAG_W-1:0]  resp1_tag
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

  state_t state_reg;
  state_t state_next;

  logic              ptr_reg;
  logic              owner_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [F_W-1:0]    f_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] y_reg;
  logic              zero_reg;

  logic [1:0] req_valid_vec;
  logic [1:0] grant;
  logic [1:0] req_ready_vec;
  logic [1:0] resp_ready_vec;
  logic [1:0] resp_valid_vec;

  logic in_idle;
  logic in_exec;
  logic in_resp;
  logic accept;
  logic sel;
  logic cnt_zero;
  logic resp_done;

  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [F_W-1:0]    sel_f;
  logic [TAG_W-1:0]  sel_tag;

  logic [DATA_W-1:0] alu_y;
  logic              alu_zero;

  assign req_valid_vec  = {req1_valid, req0_valid};
  assign resp_ready_vec = {resp1_ready, resp0_ready};

  rr_arbiter_2 u_rr (
    .valid (req_valid_vec),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  // grant is one-hot whenever any request is present, so grant[1] alone picks the payload
  assign sel     = grant[1];
  assign sel_a   = sel ? req1_a   : req0_a;
  assign sel_b   = sel ? req1_b   : req0_b;
  assign sel_f   = sel ? req1_f   : req0_f;
  assign sel_tag = sel ? req1_tag : req0_tag;

  assign accept    = in_idle && (grant != 2'b00);
  assign cnt_zero  = (cnt_reg == '0);
  assign resp_done = in_resp && resp_ready_vec[owner_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept)    state_next = ST_EXEC;
      ST_EXEC: if (cnt_zero)  state_next = ST_RESP;
      ST_RESP: if (resp_done) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_idle = 1'b0;
    in_exec = 1'b0;
    in_resp = 1'b0;
    case (state_reg)
      ST_IDLE: in_idle = 1'b1;
      ST_EXEC: in_exec = 1'b1;
      ST_RESP: in_resp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= 1'b0;
      owner_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      f_reg     <= '0;
      tag_reg   <= '0;
      cnt_reg   <= '0;
      y_reg     <= '0;
      zero_reg  <= 1'b0;
    end else if (accept) begin
      a_reg     <= sel_a;
      b_reg     <= sel_b;
      f_reg     <= sel_f;
      tag_reg   <= sel_tag;
      owner_reg <= sel;
      ptr_reg   <= ~sel;
      cnt_reg   <= is_mul_op(sel_f[F_OP_HI:F_OP_LO]) ? MUL_CNT : '0;
    end else if (in_exec) begin
      if (!cnt_zero) begin
        cnt_reg <= cnt_reg - 4'd1;
      end else begin
        y_reg    <= alu_y;
        zero_reg <= alu_zero;
      end
    end
  end

  alu u_alu (
    .a    (a_reg),
    .b    (b_reg),
    .f    (f_reg),
    .y    (alu_y),
    .zero (alu_zero)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready_vec[gi]  = in_idle && grant[gi];
      assign resp_valid_vec[gi] = in_resp && (owner_reg == 1'(gi));
    end
  endgenerate

  // Result fields are driven only toward the owning requester while its response is valid
  assign req0_ready  = req_ready_vec[0];
  assign req1_ready  = req_ready_vec[1];
  assign resp0_valid = resp_valid_vec[0];
  assign resp1_valid = resp_valid_vec[1];
  assign resp0_y     = resp_valid_vec[0] ? y_reg    : '0;
  assign resp1_y     = resp_valid_vec[1] ? y_reg    : '0;
  assign resp0_zero  = resp_valid_vec[0] ? zero_reg : 1'b0;
  assign resp1_zero  = resp_valid_vec[1] ? zero_reg : 1'b0;
  assign resp0_tag   = resp_valid_vec[0] ? tag_reg  : '0;
  assign resp1_tag   = resp_valid_vec[1] ? tag_reg  : '0;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the team's 64-bit `alu` between two requesters (e.g. integer pipe and address-generation unit). Round-robin arbitration, valid/ready handshakes on request and response sides, registered operands and results, and a multi-cycle hold for multiply ops. One transaction in flight at a time. Responses are returned to the granted requester with its tag.

## Interface
- `TAG_W`, default 4: width of the requester tag carried through unchanged.
- `MUL_LAT`, default 2: EXEC cycles for ops 0x8/0x9; legal range 1–15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  64  operands.
- `req0_f` / `req1_f`  in  7  ALU function: [6] invert a, [5] invert b, [4:1] op, [0] invert result.
- `req0_tag` / `req1_tag`  in  TAG_W  requester tag.
- `resp0_valid` / `resp1_valid`  out  1  result available.
- `resp0_ready` / `resp1_ready`  in  1  requester takes result.
- `resp0_y` / `resp1_y`  out  64  ALU result.
- `resp0_zero` / `resp1_zero`  out  1  result == 0.
- `resp0_tag` / `resp1_tag`  out  TAG_W  tag of the accepted request.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: arbitrate; `reqN_ready` = (state==IDLE) && grant==N, combinational from valids and priority pointer. On accept, latch a, b, f, tag, owner id; load exec counter (MUL_LAT−1 if f[4:1] ∈ {0x8,0x9}, else 0); go EXEC.
- Arbitration: one valid → that one wins. Both valid → requester selected by pointer wins. Pointer moves to the non-winner on every accept.
- EXEC: ALU driven from latched operands only. Counter nonzero → decrement, stay. Counter zero → capture y and zero into result regs, go RESP.
- RESP: `respN_valid`=1 for owner only; y, zero, tag stable. On `respN_ready` → IDLE. Non-owner resp_valid stays 0.
- All ops 0x0–0xF forwarded unmodified; 0xC–0xF yield 0 (or all-ones with f[0]=1). No op is rejected.
- Requester rule: valid, once high, holds with stable payload until ready; valid must not depend on ready. Arbiter does not check this.

## Timing
- Reset values: state IDLE, pointer → requester 0, all `reqN_ready`/`respN_valid` 0, result/operand regs 0, `respN_y` 0, `respN_zero` 0, `respN_tag` 0.
- Latency, accept edge T → `resp_valid` high after edge T+2 (non-mul) or T+1+MUL_LAT (mul).
- Max throughput: one op per 3 cycles (resp_ready held high, non-mul); one per 2+MUL_LAT for mul.
- Backpressure: resp_ready low holds RESP indefinitely; no new grants, both req_ready 0.
- Request arriving in EXEC/RESP: waits, not lost; arbitrated on return to IDLE.
- Reset asserted mid-EXEC/RESP: transaction dropped, no response, outputs to reset values asynchronously.

## Structure
- Package `alu_ctrl_pkg`: state enum, op constants OP_AND…OP_RSHIFT (0x0–0xB), OP_MUL=0x8, OP_MULH=0x9, f-field bit positions, `is_mul_op` function.
- Sub-module `rr_arbiter_2`: 2-way round-robin grant, inputs valids + pointer, outputs one-hot grant; pointer register lives in `alu_arbiter`.
- One `alu` instance; no other datapath logic.

## Test plan
- Reset then req0 a=5 b=3 f=0x06 (sum) tag=2 → accepted in cycle 0, resp0 valid cycle 2, y=8, zero=0, tag=2; resp1_valid never asserts.
- Both valid after reset: req0 f=0x06 a=1 b=1, req1 f=0x04 (xor) a=7 b=7 → req0 first (y=2), then req1 (y=0, zero=1); repeat both → req1 granted first on next contention only if pointer says so; check alternation over 8 back-to-back pairs (4/4 split).
- Mul with MUL_LAT=3: req1 a=0xFFFF_FFFF_FFFF_FFFF b=2 f=0x10 → resp at T+4, y=0xFFFF_FFFF_FFFF_FFFE; f=0x12 → y=1.
- Subtract via inversion: a=10 b=3 f=0x26 → y=7; a=3 b=10 → y=0xFFFF_FFFF_FFFF_FFF9.
- Backpressure: resp0_ready low for 10 cycles with req1 valid → resp0 payload stable, req1_ready stays 0; release → req1 accepted the cycle after IDLE entry.
- rst_n pulsed low during EXEC → no response emitted, all outputs 0 immediately, next request processed normally with pointer at requester 0.
